// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - RV32M op codes, sequencer states and shared constants
package muldiv_pkg;

    localparam logic [4:0] OP_MUL    = 5'b01011;
    localparam logic [4:0] OP_MULH   = 5'b01100;
    localparam logic [4:0] OP_MULHSU = 5'b01101;
    localparam logic [4:0] OP_MULHU  = 5'b01110;
    localparam logic [4:0] OP_DIV    = 5'b01111;
    localparam logic [4:0] OP_DIVU   = 5'b10000;
    localparam logic [4:0] OP_REM    = 5'b10001;
    localparam logic [4:0] OP_REMU   = 5'b10010;

    localparam int DIV_ITERS = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // M codes occupy one contiguous range, multiplies below divides
    function automatic logic is_m_op(input logic [4:0] op);
        return (op >= OP_MUL) && (op <= OP_REMU);
    endfunction

    function automatic logic is_div_op(input logic [4:0] op);
        return (op >= OP_DIV) && (op <= OP_REMU);
    endfunction

    function automatic logic is_signed_div(input logic [4:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_quo_op(input logic [4:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_sequencer_div_step.sv
// rtl/muldiv_sequencer_div_step.sv - one restoring radix-2 divide iteration
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] dvs_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN:0] shifted;
    logic          ge;

    assign shifted = {rem_i, quo_i[XLEN-1]};
    assign ge      = shifted >= {1'b0, dvs_i};

    // A successful subtract leaves a value below the divisor, so XLEN bits suffice
    assign rem_o = ge ? (shifted[XLEN-1:0] - dvs_i) : shifted[XLEN-1:0];
    assign quo_o = {quo_i[XLEN-2:0], ge};

endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - multi-cycle RV32M multiply/divide sequencer for Execute
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int MUL_LAT = 2,
    parameter int XLEN    = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [4:0]      op_i,
    input  logic [XLEN-1:0] src_a_i,
    input  logic [XLEN-1:0] src_b_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    state_t          state_q, state_d;
    logic [4:0]      op_q;
    logic [4:0]      cnt_q;
    logic [XLEN-1:0] a_q, b_q;
    logic [XLEN-1:0] rem_q, quo_q, dvs_q;
    logic            neg_quo_q, neg_rem_q;
    logic [XLEN-1:0] result_q;

    logic            accept;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] special_result;

    logic [XLEN-1:0] step_rem, step_quo;
    logic [XLEN-1:0] div_result;

    logic            sx_a, sx_b;
    logic signed [63:0] mul_a, mul_b, product;
    logic [XLEN-1:0] mul_result;

    assign accept = rst_n && (state_q == ST_IDLE) && start_i && is_m_op(op_i) && !flush_i;

    // Accept-time decode of divide operands and the no-iteration cases
    assign a_neg    = is_signed_div(op_i) && src_a_i[XLEN-1];
    assign b_neg    = is_signed_div(op_i) && src_b_i[XLEN-1];
    assign a_mag    = a_neg ? (~src_a_i + 1'b1) : src_a_i;
    assign b_mag    = b_neg ? (~src_b_i + 1'b1) : src_b_i;
    assign div_zero = (src_b_i == '0);
    assign div_ovf  = is_signed_div(op_i) && (src_a_i == {1'b1, {(XLEN-1){1'b0}}})
                      && (src_b_i == '1);
    assign special  = is_div_op(op_i) && (div_zero || div_ovf);

    always_comb begin
        special_result = '0;
        if (div_zero) begin
            special_result = is_quo_op(op_i) ? '1 : src_a_i;
        end else if (is_quo_op(op_i)) begin
            special_result = {1'b1, {(XLEN-1){1'b0}}};
        end
    end

    div_step #(.XLEN(XLEN)) u_div_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    always_comb begin
        div_result = '0;
        if (is_quo_op(op_q)) begin
            div_result = neg_quo_q ? (~step_quo + 1'b1) : step_quo;
        end else begin
            div_result = neg_rem_q ? (~step_rem + 1'b1) : step_rem;
        end
    end

    // 33-bit extended operands, carried at 64 bits so the product needs no truncation
    assign sx_a    = (op_q == OP_MULH) || (op_q == OP_MULHSU);
    assign sx_b    = (op_q == OP_MULH);
    assign mul_a   = {{32{sx_a & a_q[XLEN-1]}}, a_q};
    assign mul_b   = {{32{sx_b & b_q[XLEN-1]}}, b_q};
    assign product = mul_a * mul_b;
    assign mul_result = (op_q == OP_MUL) ? product[31:0] : product[63:32];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stall_o = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    stall_o = 1'b1;
                    if (!is_div_op(op_i)) begin
                        state_d = ST_MUL;
                    end else if (special) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_DIV;
                    end
                end
            end
            ST_MUL: begin
                stall_o = 1'b1;
                if (cnt_q == '0) state_d = ST_DONE;
            end
            ST_DIV: begin
                stall_o = 1'b1;
                if (cnt_q == '0) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (flush_i) state_d = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= '0;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
        end else if (accept) begin
            op_q      <= op_i;
            a_q       <= src_a_i;
            b_q       <= src_b_i;
            rem_q     <= '0;
            quo_q     <= a_mag;
            dvs_q     <= b_mag;
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            cnt_q     <= is_div_op(op_i) ? 5'(DIV_ITERS - 1) : 5'(MUL_LAT - 1);
            if (special) result_q <= special_result;
        end else if (!flush_i && state_q == ST_DIV) begin
            rem_q <= step_rem;
            quo_q <= step_quo;
            cnt_q <= cnt_q - 5'd1;
            if (cnt_q == '0) result_q <= div_result;
        end else if (!flush_i && state_q == ST_MUL) begin
            cnt_q <= cnt_q - 5'd1;
            if (cnt_q == '0) result_q <= mul_result;
        end
    end

    assign busy_o   = (state_q != ST_IDLE);
    assign done_o   = (state_q == ST_DONE);
    assign result_o = result_q;

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle sequencer for the RV32M operations issued from the Execute stage. It owns a fixed-latency pipelined multiplier and an iterative radix-2 divider. It stalls the pipeline while an M-extension operation is in flight and returns one 32-bit result with a single-cycle done strobe. It sits beside the ALU in the Execute stage, and its stall output feeds the hazard unit.

## Interface
- MUL_LAT, 2: cycles spent in the MUL state; legal range 1–4.
- XLEN, 32: operand and result width; only 32 is supported.
- clk  in  1  Core clock; all state changes on the rising edge.
- rst_n  in  1  Reset, active-low, asynchronous. This polarity and synchronicity are already decided.
- start_i  in  1  The Execute stage holds an unflushed instruction.
- op_i  in  5  Execute-stage ALU op code. M codes are:
  - MUL 01011, MULH 01100, MULHSU 01101, MULHU 01110
  - DIV 01111, DIVU 10000, REM 10001, REMU 10010
- src_a_i, src_b_i  in  32  Operands. They are sampled only on accept.
- flush_i  in  1  The Execute-stage instruction is killed (branch/trap).
- stall_o  out  1  Freeze IF/ID/EX and insert a bubble into MEM.
- busy_o  out  1  State is not IDLE.
- done_o  out  1  One-cycle strobe; result_o is valid.
- result_o  out  32  Last completed result, held until the next accept.

## Operation
- States are IDLE, MUL, DIV and DONE.
- Accept rule:
  - An accept occurs in IDLE when start_i=1, op_i is an M code and flush_i=0.
  - On accept, the sequencer latches op, src_a_i and src_b_i.
  - Non-M codes are ignored: the state stays IDLE and stall_o stays 0.
- IDLE→MUL on accept of MUL, MULH, MULHSU or MULHU.
- MUL: a counter runs MUL_LAT cycles, then the state moves to DONE.
  - The product is computed as a 33×33 signed multiply with 64-bit output.
  - Operand extension:
    - MULH: sign-extend both operands.
    - MULHSU: sign-extend A, zero-extend B.
    - MULHU and MUL: zero-extend both operands.
  - MUL returns bits [31:0]; the others return bits [63:32].
- IDLE→DIV on accept of a divide or remainder op, except for the special cases below.
- DIV: runs 32 restoring iterations on magnitudes.
  - A 5-bit counter counts 31 down to 0; the state moves to DONE after the iteration at count 0.
  - Signed ops: the quotient is negated if the operand signs differ; the remainder takes the sign of the dividend.
- Special cases go IDLE→DONE directly, with no iterations:
  - Divisor 0: the quotient is 0xFFFFFFFF and the remainder is the dividend.
  - DIV or REM with 0x80000000 / 0xFFFFFFFF: the quotient is 0x80000000 and the remainder is 0.
- DONE: done_o=1 and result_o is updated. The state always returns to IDLE next cycle, and start_i is ignored in DONE because it is the same instruction.
- Combinational outputs:
  - stall_o = (IDLE & accept) | MUL | DIV.
  - stall_o = 0 in DONE, so the pipeline advances that cycle.
- Flush:
  - flush_i in any state forces IDLE next cycle, with no done_o.
  - result_o keeps its previous value.
  - Flush beats start in IDLE.
- Reset:
  - rst_n low immediately forces IDLE.
  - Reset values: stall_o=0, busy_o=0, done_o=0, result_o=0, and all counters and operand registers 0.
  - An in-flight operation is discarded.

## Timing
Latency is counted from the accept cycle N.
- Multiply:
  - stall_o is high at N..N+MUL_LAT.
  - done_o is at N+MUL_LAT+1.
  - With MUL_LAT=2, the instruction occupies Execute for 4 cycles.
- Divide: stall_o is high at N..N+32, and done_o is at N+33.
- Divide special case: stall_o is high at N only, and done_o is at N+1.
- Back-to-back M ops: the earliest next accept is DONE+1.
- The operand registers isolate the sequencer from Execute-stage changes after accept.

## Structure
- muldiv_pkg holds the M op-code localparams (shared with ALU decode), the state enum, and the DIV_ITERS=32 constant.
- One sub-module, div_step, performs one restoring iteration: inputs are remainder, quotient and divisor; outputs are the next remainder and quotient. The sequencer registers its outputs each DIV cycle.
- The multiplier and the FSM stay inline.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3):
  - result_o=0xFFFFFFEB.
  - done_o at N+3 (MUL_LAT=2), stall_o high for 3 cycles.
- MULH, MULHSU and MULHU, each with both operands 0xFFFFFFFF:
  - Results are 0x00000000, 0xFFFFFFFF and 0xFFFFFFFE.
- DIV −7/2 gives 0xFFFFFFFD, REM −7/2 gives 0xFFFFFFFF, and DIVU 100/7 gives 14.
  - done_o at N+33 for each.
- Divide special cases, each with done_o at N+1:
  - DIV 5/0 gives 0xFFFFFFFF.
  - REMU 5/0 gives 5.
  - DIV 0x80000000/0xFFFFFFFF gives 0x80000000.
  - REM of the same operands gives 0.
- Flush during divide:
  - Pulse flush_i at N+10 of a DIV: state is IDLE at N+11, with no done_o and result_o unchanged.
  - A MUL presented at N+11 is accepted.
- Reset mid-operation:
  - Drop rst_n mid-DIV between clock edges: all outputs are 0 immediately.
  - After release, a DIVU 9/3 returns 3.
